// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares the single data-memory port between the CPU core and the FPGA I/O front end.
// One transfer is outstanding at a time. Define ARB_TIMEOUT_EN to abort transfers whose mem_ack never arrives.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              fpga_req,
    input  logic              fpga_we,
    input  logic [ADDR_W-1:0] fpga_addr,
    input  logic [DATA_W-1:0] fpga_wdata,
    output logic [DATA_W-1:0] fpga_rdata,
    output logic              fpga_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        grant,
    output logic              bus_err
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CPU_XFER  = 2'd1;
    localparam logic [1:0] ST_FPGA_XFER = 2'd2;
    localparam logic [1:0] ST_RELEASE   = 2'd3;

    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT must be at least 2");
    end

    logic [1:0] state;
    logic       last_fpga;
    logic       cpu_win;
    logic       fpga_win;
    logic       timed_out;
    logic       finish;

    // On a tie the master that did not win last time gets the bus.
    assign cpu_win  = cpu_req && (!fpga_req || last_fpga);
    assign fpga_win = fpga_req && !cpu_win;
    assign finish   = mem_ack || timed_out;

`ifdef ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic             in_xfer;
    logic [CNT_W-1:0] xfer_cnt;
    logic             err;

    assign in_xfer   = (state == ST_CPU_XFER) || (state == ST_FPGA_XFER);
    // A mem_ack in the final counted cycle still wins over the abort.
    assign timed_out = in_xfer && !mem_ack && (xfer_cnt == CNT_LAST);
    assign bus_err   = err;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            xfer_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= timed_out;
            if (!in_xfer) begin
                xfer_cnt <= '0;
            end else if (!finish) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
        end
    end
`else
    assign timed_out = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            last_fpga  <= 1'b1;
            grant      <= 2'b00;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            fpga_ack   <= 1'b0;
            cpu_rdata  <= '0;
            fpga_rdata <= '0;
        end else begin
            cpu_ack  <= 1'b0;
            fpga_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_win || fpga_win) begin
                        state     <= cpu_win ? ST_CPU_XFER : ST_FPGA_XFER;
                        grant     <= {fpga_win, cpu_win};
                        last_fpga <= fpga_win;
                        mem_req   <= 1'b1;
                        mem_we    <= cpu_win ? cpu_we    : fpga_we;
                        mem_addr  <= cpu_win ? cpu_addr  : fpga_addr;
                        mem_wdata <= cpu_win ? cpu_wdata : fpga_wdata;
                    end
                end
                ST_CPU_XFER, ST_FPGA_XFER: begin
                    // Writes leave the winner's read data untouched unless the transfer aborts.
                    if (finish) begin
                        state   <= ST_RELEASE;
                        grant   <= 2'b00;
                        mem_req <= 1'b0;
                        if (state == ST_CPU_XFER) begin
                            cpu_ack <= 1'b1;
                            if (timed_out || !mem_we) begin
                                cpu_rdata <= timed_out ? ERR_DATA : mem_rdata;
                            end
                        end else begin
                            fpga_ack <= 1'b1;
                            if (timed_out || !mem_we) begin
                                fpga_rdata <= timed_out ? ERR_DATA : mem_rdata;
                            end
                        end
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by randomized masters and memory,
// every cycle compared against a transfer-level reference model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 64;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              nrst;
    logic              cpu_req, cpu_we, cpu_ack;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              fpga_req, fpga_we, fpga_ack;
    logic [ADDR_W-1:0] fpga_addr;
    logic [DATA_W-1:0] fpga_wdata, fpga_rdata;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [1:0]        grant;
    logic              bus_err;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .nrst(nrst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .fpga_req(fpga_req), .fpga_we(fpga_we), .fpga_addr(fpga_addr), .fpga_wdata(fpga_wdata),
        .fpga_rdata(fpga_rdata), .fpga_ack(fpga_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .grant(grant), .bus_err(bus_err)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_done      = 0;
    int lat         = 0;

    // Reference model: who owns the bus, whether we sit in the post-transfer cycle, and expected outputs.
    int                m_owner     = 0;     // 0 none, 1 cpu, 2 fpga
    bit                m_rel       = 1'b0;
    bit                m_last_fpga = 1'b1;
    int                m_start     = 0;
    logic              m_we        = 1'b0;
    logic [ADDR_W-1:0] m_addr      = '0;
    logic [DATA_W-1:0] m_wdata     = '0;
    logic [DATA_W-1:0] e_cpu_rdata = '0;
    logic [DATA_W-1:0] e_fpga_rdata = '0;
    logic              e_cpu_ack, e_fpga_ack, e_err;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock: snapshot the inputs the edge will sample, update the model, compare.
    task automatic step();
        logic              s_nrst, s_creq, s_cwe, s_freq, s_fwe, s_mack;
        logic [ADDR_W-1:0] s_caddr, s_faddr;
        logic [DATA_W-1:0] s_cwd, s_fwd, s_mrd;
        logic [1:0]        e_grant;
        int                win;
        bit                timed;
        s_nrst = nrst;     s_mack = mem_ack;   s_mrd = mem_rdata;
        s_creq = cpu_req;  s_cwe = cpu_we;     s_caddr = cpu_addr;   s_cwd = cpu_wdata;
        s_freq = fpga_req; s_fwe = fpga_we;    s_faddr = fpga_addr;  s_fwd = fpga_wdata;
        @(negedge clk);
        cyc++;
        e_cpu_ack = 1'b0; e_fpga_ack = 1'b0; e_err = 1'b0;
        if (!s_nrst) begin
            m_owner = 0; m_rel = 1'b0; m_last_fpga = 1'b1;
            m_we = 1'b0; m_addr = '0; m_wdata = '0;
            e_cpu_rdata = '0; e_fpga_rdata = '0;
        end else if (m_owner == 0) begin
            if (m_rel) begin
                m_rel = 1'b0;
            end else if (s_creq || s_freq) begin
                if (s_creq && s_freq) win = m_last_fpga ? 1 : 2;
                else win = s_creq ? 1 : 2;
                m_owner = win; m_last_fpga = (win == 2); m_start = cyc;
                m_we    = (win == 1) ? s_cwe   : s_fwe;
                m_addr  = (win == 1) ? s_caddr : s_faddr;
                m_wdata = (win == 1) ? s_cwd   : s_fwd;
            end
        end else begin
            timed = TO_EN && !s_mack && (cyc - m_start == TIMEOUT);
            if (s_mack || timed) begin
                if (m_owner == 1) begin
                    e_cpu_ack = 1'b1;
                    if (timed) e_cpu_rdata = 32'hDEAD_BEEF;
                    else if (!m_we) e_cpu_rdata = s_mrd;
                end else begin
                    e_fpga_ack = 1'b1;
                    if (timed) e_fpga_rdata = 32'hDEAD_BEEF;
                    else if (!m_we) e_fpga_rdata = s_mrd;
                end
                e_err = timed; m_owner = 0; m_rel = 1'b1; n_done++;
            end
        end
        e_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        check_val("grant",      64'(grant),      64'(e_grant));
        check_val("mem_req",    64'(mem_req),    64'(m_owner != 0));
        check_val("mem_we",     64'(mem_we),     64'(m_we));
        check_val("mem_addr",   64'(mem_addr),   64'(m_addr));
        check_val("mem_wdata",  64'(mem_wdata),  64'(m_wdata));
        check_val("cpu_ack",    64'(cpu_ack),    64'(e_cpu_ack));
        check_val("fpga_ack",   64'(fpga_ack),   64'(e_fpga_ack));
        check_val("cpu_rdata",  64'(cpu_rdata),  64'(e_cpu_rdata));
        check_val("fpga_rdata", 64'(fpga_rdata), 64'(e_fpga_rdata));
        check_val("bus_err",    64'(bus_err),    64'(e_err));
    endtask

    task automatic wait_grant();
        int n = 0;
        while (grant == 2'b00 && n < 20) begin
            step();
            n++;
        end
        check_val("wait_grant", 64'(grant != 2'b00), 64'(1));
    endtask

    task automatic master_next(input logic ack, inout logic req, inout logic we,
                               inout logic [ADDR_W-1:0] addr, inout logic [DATA_W-1:0] wdata);
        if ((ack && $urandom_range(0, 1) == 1) || (!ack && !req && $urandom_range(0, 3) == 0)) begin
            req = 1'b1; we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
        end else if (ack || (req && $urandom_range(0, 31) == 0)) begin
            req = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] prev;
        int                n;
        bit                got;
        nrst = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        fpga_req = 1'b0; fpga_we = 1'b0; fpga_addr = '0; fpga_wdata = '0;
        step(); step();
        check_val("rst_grant", 64'(grant), 64'(0));
        check_val("rst_mem_req", 64'(mem_req), 64'(0));
        check_val("rst_acks", 64'({cpu_ack, fpga_ack, bus_err}), 64'(0));

        // Single CPU read of address 280, memory answers two cycles later with 2Ah.
        nrst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd280;
        step();
        check_val("t1_mem_req", 64'(mem_req), 64'(1));
        check_val("t1_grant", 64'(grant), 64'(2'b01));
        check_val("t1_addr", 64'(mem_addr), 64'(280));
        step(); step();
        check_val("t1_no_ack_yet", 64'(cpu_ack), 64'(0));
        mem_ack = 1'b1; mem_rdata = 32'h2A;
        step();
        check_val("t1_cpu_ack", 64'(cpu_ack), 64'(1));
        check_val("t1_rdata", 64'(cpu_rdata), 64'(32'h2A));
        check_val("t1_grant_idle", 64'(grant), 64'(0));
        mem_ack = 1'b0; cpu_req = 1'b0;
        step();
        check_val("t1_ack_pulse", 64'(cpu_ack), 64'(0));
        check_val("t1_rdata_hold", 64'(cpu_rdata), 64'(32'h2A));

        // Simultaneous requests after reset, both held: grants must alternate starting with CPU.
        nrst = 1'b0; step();
        nrst = 1'b1; cpu_req = 1'b1; fpga_req = 1'b1;
        cpu_addr = 32'd1; fpga_addr = 32'd2; cpu_we = 1'b0; fpga_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_grant();
            check_val("t2_rr_grant", 64'(grant), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
            mem_ack = 1'b1; mem_rdata = 32'h100 + k;
            step();
            mem_ack = 1'b0;
            step();
        end
        cpu_req = 1'b0; fpga_req = 1'b0;
        step();

        // FPGA write with its inputs changing mid-transfer; read data must not move.
        fpga_req = 1'b1; fpga_we = 1'b1; fpga_addr = 32'd220; fpga_wdata = 32'h12;
        wait_grant();
        fpga_addr = 32'd999; fpga_wdata = 32'hFFFF; fpga_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("t3_mem_fields", 64'({mem_we, mem_addr[15:0], mem_wdata[15:0]}),
                      64'({1'b1, 16'd220, 16'h12}));
        end
        mem_ack = 1'b1; mem_rdata = 32'h55;
        step();
        check_val("t3_fpga_ack", 64'(fpga_ack), 64'(1));
        check_val("t3_bus_err", 64'(bus_err), 64'(0));
        check_val("t3_rdata_kept", 64'(fpga_rdata), 64'(32'h103));
        mem_ack = 1'b0; fpga_req = 1'b0;
        step(); step();

        // Reset in the middle of a CPU transfer.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd7;
        wait_grant();
        step();
        nrst = 1'b0; cpu_req = 1'b0;
        step();
        check_val("t4_mem_req", 64'(mem_req), 64'(0));
        check_val("t4_grant", 64'(grant), 64'(0));
        check_val("t4_no_ack", 64'(cpu_ack), 64'(0));
        nrst = 1'b1;
        step();
        cpu_req = 1'b1; fpga_req = 1'b1;
        wait_grant();
        check_val("t4_cpu_first", 64'(grant), 64'(2'b01));
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; cpu_req = 1'b0; fpga_req = 1'b0;
        step(); step();

        // Stray mem_ack while idle, then CPU request noise during an FPGA transfer.
        mem_ack = 1'b1;
        step();
        check_val("t5_idle_ack", 64'({cpu_ack, fpga_ack, mem_req}), 64'(0));
        mem_ack = 1'b0; fpga_req = 1'b1; fpga_we = 1'b0; fpga_addr = 32'd240;
        wait_grant();
        for (int k = 0; k < 6; k++) begin
            cpu_req = 1'(k % 2); cpu_addr = $urandom;
            step();
            check_val("t5_addr_held", 64'(mem_addr), 64'(240));
        end
        cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77;
        step();
        check_val("t5_acks", 64'({cpu_ack, fpga_ack}), 64'(2'b01));
        check_val("t5_rdata", 64'(fpga_rdata), 64'(32'h77));
        mem_ack = 1'b0; fpga_req = 1'b0;
        step(); step();

        // Memory never answers.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd260;
        wait_grant();
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            step();
            n++;
            if (cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0;
`ifdef ARB_TIMEOUT_EN
        check_val("t6_timeout_cycles", 64'(n), 64'(TIMEOUT));
        check_val("t6_bus_err", 64'(bus_err), 64'(1));
        check_val("t6_err_data", 64'(cpu_rdata), 64'(32'hDEAD_BEEF));
        step();
`else
        check_val("t6_no_ack", 64'(got), 64'(0));
        mem_ack = 1'b1; mem_rdata = 32'h3C;
        step();
        mem_ack = 1'b0;
        step();
`endif
        step();

        // Randomized masters and memory.
        n_done = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            master_next(cpu_ack, cpu_req, cpu_we, cpu_addr, cpu_wdata);
            master_next(fpga_ack, fpga_req, fpga_we, fpga_addr, fpga_wdata);
            mem_ack = 1'b0;
            if (mem_req) begin
                if (lat == 0) begin
                    mem_ack = 1'b1; mem_rdata = $urandom; lat = $urandom_range(0, 3);
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ack = 1'b1; mem_rdata = $urandom;
            end
        end
        check_val("rand_progress", 64'(n_done > 100), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
